// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned ADDR_W = 10;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StWr0,
    StRd1,
    StWr1,
    StResp
  } lsu_state_e;

  // Number of bytes touched by an access; the illegal size never reaches memory.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Right-aligned lane mask covering the bytes of an access.
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      SZ_BYTE: m = 32'h0000_00FF;
      SZ_HALF: m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // An access is split when it runs past the end of its first word.
  function automatic logic is_split(input logic [1:0] off, input logic [1:0] size);
    return ({1'b0, off} + size_nbytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane merge for read-modify-write stores and extraction/extension for loads.
module lsu_align import lsu_pkg::*; (
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_buf,
  input  logic [31:0] hi_buf,
  output logic [31:0] lo_merged,
  output logic [31:0] hi_merged,
  output logic [31:0] rdata
);

  logic [5:0]  shamt;
  logic [63:0] mask_sh;
  logic [63:0] wdata_sh;
  logic [31:0] window;

  assign shamt = {off, 3'b000};

  // Store data and its lane mask placed across the two-word window.
  assign mask_sh  = {32'h0, size_mask(size)} << shamt;
  assign wdata_sh = {32'h0, wdata & size_mask(size)} << shamt;

  assign lo_merged = (lo_buf & ~mask_sh[31:0])  | (wdata_sh[31:0]  & mask_sh[31:0]);
  assign hi_merged = (hi_buf & ~mask_sh[63:32]) | (wdata_sh[63:32] & mask_sh[63:32]);

  assign window = 32'({hi_buf, lo_buf} >> shamt);

  // Truncate the loaded window to the access size, then sign- or zero-extend.
  always_comb begin
    rdata = 32'h0;
    case (size)
      SZ_BYTE: rdata = {{24{~load_unsigned & window[7]}}, window[7:0]};
      SZ_HALF: rdata = {{16{~load_unsigned & window[15]}}, window[15:0]};
      SZ_WORD: rdata = window;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide memory, with split
// accesses across word boundaries and read-modify-write for sub-word stores.
module load_store_unit import lsu_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_byteen,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_q;

  logic              accept;
  logic              split;
  logic [ADDR_W-3:0] word_addr;
  logic [31:0]       lo_merged;
  logic [31:0]       hi_merged;
  logic [31:0]       load_data;

  assign accept    = req_valid && (state_q == StIdle);
  assign split     = is_split(addr_q[1:0], size_q);
  assign word_addr = addr_q[ADDR_W-1:2];

  lsu_align u_align (
    .off           (addr_q[1:0]),
    .size          (size_q),
    .load_unsigned (unsigned_q),
    .wdata         (wdata_q),
    .lo_buf        (lo_q),
    .hi_buf        (hi_q),
    .lo_merged     (lo_merged),
    .hi_merged     (hi_merged),
    .rdata         (load_data)
  );

  // State register; async reset aborts any access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
    end else if (accept) begin
      we_q       <= req_we;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
    end
  end

  // Capture read data from the low and high words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= 32'h0;
      hi_q <= 32'h0;
    end else begin
      if (state_q == StRd0) lo_q <= mem_dout;
      if (state_q == StRd1) hi_q <= mem_dout;
    end
  end

  // Next state and outputs; all outputs decode from registers only so they hold
  // steady through the falling edge where the memory samples writes.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = 32'h0;
    rsp_err    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_byteen = 4'h0;
    mem_din    = 32'h0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_size == SZ_ILL) begin
            state_d = StResp;
          end else if (req_we && req_size == SZ_WORD && req_addr[1:0] == 2'd0) begin
            state_d = StWr0;
          end else begin
            state_d = StRd0;
          end
        end
      end
      StRd0: begin
        mem_byteen = 4'hF;
        mem_addr   = word_addr;
        if (we_q) begin
          state_d = StWr0;
        end else begin
          state_d = split ? StRd1 : StResp;
        end
      end
      StWr0: begin
        mem_we     = 1'b1;
        mem_byteen = 4'hF;
        mem_addr   = word_addr;
        mem_din    = lo_merged;
        state_d    = split ? StRd1 : StResp;
      end
      StRd1: begin
        mem_byteen = 4'hF;
        mem_addr   = word_addr + 1'b1;
        state_d    = we_q ? StWr1 : StResp;
      end
      StWr1: begin
        mem_we     = 1'b1;
        mem_byteen = 4'hF;
        mem_addr   = word_addr + 1'b1;
        mem_din    = hi_merged;
        state_d    = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_err   = (size_q == SZ_ILL);
        if (!we_q && size_q != SZ_ILL) rsp_rdata = load_data;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a falling-edge-write memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = 10'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_byteen   (mem_byteen),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  // Memory model: masked combinational read, write sampled on the falling edge.
  logic [31:0] mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = 8'h0;
  logic [31:0] bd_data = 32'h0;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  assign mem_dout = mem[mem_addr] & be_mask(mem_byteen);

  always @(negedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_din & be_mask(mem_byteen);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] addr_log[$];
  int         we_seen;

  task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  // Issue one request, push its expected response, then drain the scoreboard.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    exp_t e;
    exp_t got;
    @(negedge clk);
    check_eq("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = 32'(cyc + lat);
    sb_q.push_back(e);
    addr_log.delete();
    we_seen = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      if (mem_byteen == 4'hF) addr_log.push_back(mem_addr);
      if (mem_we) we_seen++;
      if (rsp_valid) begin
        got = sb_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, got.rdata);
        check_eq("rsp_err", {31'b0, rsp_err}, {31'b0, got.err});
        check_eq("rsp_cycle", 32'(cyc), got.cyc);
      end
    end
    check_eq("rsp_pending", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp_cnt;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check_eq("rst_mem_byteen", {28'b0, mem_byteen}, 32'd0);
    check_eq("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    check_eq("rst_mem_din", mem_din, 32'd0);
    rst_n = 1'b1;

    bd_write(8'd5,   32'h8899AABB);
    bd_write(8'd255, 32'hDD000000);
    bd_write(8'd0,   32'h00CCBBAA);
    bd_write(8'd1,   32'h11111111);
    bd_write(8'd2,   32'h22222222);
    bd_write(8'd6,   32'h000000F0);
    bd_write(8'd7,   32'h11223344);

    // lb / lbu
    do_req(1'b0, 2'd0, 1'b0, 10'h016, 32'h0, 32'hFFFFFF99, 1'b0, 2);
    do_req(1'b0, 2'd0, 1'b1, 10'h016, 32'h0, 32'h00000099, 1'b0, 2);

    // sh non-split via read-modify-write, then read back
    do_req(1'b1, 2'd1, 1'b0, 10'h015, 32'h00001234, 32'h0, 1'b0, 3);
    check_eq("sh_mem5", mem[5], 32'h881234BB);
    check_eq("sh_we_count", 32'(we_seen), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 10'h014, 32'h0, 32'h881234BB, 1'b0, 2);

    // split signed half, aligned unsigned half
    do_req(1'b0, 2'd1, 1'b0, 10'h017, 32'h0, 32'hFFFFF088, 1'b0, 3);
    do_req(1'b0, 2'd1, 1'b1, 10'h014, 32'h0, 32'h000034BB, 1'b0, 2);

    // split lw wrapping the top word to word 0
    do_req(1'b0, 2'd2, 1'b0, 10'h3FF, 32'h0, 32'hCCBBAADD, 1'b0, 3);
    check_eq("lw_split_naddr", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      check_eq("lw_split_addr0", {24'b0, addr_log[0]}, 32'h000000FF);
      check_eq("lw_split_addr1", {24'b0, addr_log[1]}, 32'h00000000);
    end

    // split sw
    do_req(1'b1, 2'd2, 1'b0, 10'h006, 32'hA1B2C3D4, 32'h0, 1'b0, 5);
    check_eq("sw_split_mem1", mem[1], 32'hC3D41111);
    check_eq("sw_split_mem2", mem[2], 32'h2222A1B2);
    check_eq("sw_split_we_count", 32'(we_seen), 32'd2);

    // aligned sw, then sb into the top lane with junk upper wdata
    do_req(1'b1, 2'd2, 1'b0, 10'h008, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check_eq("sw_mem2", mem[2], 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 10'h00B, 32'hFFFFFF7E, 32'h0, 1'b0, 3);
    check_eq("sb_mem2", mem[2], 32'h7EADBEEF);

    // illegal size, load and store
    do_req(1'b0, 2'd3, 1'b0, 10'h000, 32'h0, 32'h0, 1'b1, 1);
    check_eq("ill_ld_no_we", 32'(we_seen), 32'd0);
    do_req(1'b1, 2'd3, 1'b0, 10'h004, 32'h55555555, 32'h0, 1'b1, 1);
    check_eq("ill_st_no_we", 32'(we_seen), 32'd0);
    check_eq("ill_st_mem1", mem[1], 32'hC3D41111);

    // split sh wrapping top word to word 0
    do_req(1'b1, 2'd1, 1'b0, 10'h3FF, 32'h00005566, 32'h0, 1'b0, 5);
    check_eq("sh_split_mem255", mem[255], 32'h66000000);
    check_eq("sh_split_mem0", mem[0], 32'h00CCBB55);

    // reset asserted during WR0 of a sub-word store to word 7
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd1;
    req_addr  = 10'h01C;
    req_wdata = 32'h0000AAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check_eq("abort_we_before", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_we_dropped", {31'b0, mem_we}, 32'd0);
    check_eq("abort_ready", {31'b0, req_ready}, 32'd1);
    rsp_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    check_eq("abort_no_rsp", 32'(rsp_cnt), 32'd0);
    check_eq("abort_mem7", mem[7], 32'h11223344);
    do_req(1'b0, 2'd2, 1'b0, 10'h01C, 32'h0, 32'h11223344, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
